i2c_bus_capture: RTL

//  Passive I2C bus receiver that sits downstream of the I2C master on the shared scl/sda lines.

---
 rtl/i2c_bus_capture.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_capture.sv
// Passive I2C bus receiver.
// Synchronises and glitch-filters SCL/SDA, detects START / repeated START / STOP,
// and deserialises each 8-bit frame plus its ACK bit into a one-cycle byte strobe.
// Address bytes (first after any START) are tagged, and their R/W bit is held on rw.
module i2c_bus_capture #(
    parameter int SYNC_STAGES = 2,  // min 2
    parameter int FILT_CYC    = 3   // 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       ack_out,
    output logic       is_addr,
    output logic       rw,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       frame_err
);

    localparam int SCL = 0;
    localparam int SDA = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ACK
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and level filters
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [1:0]             line_raw;
    logic [1:0]             filt_q;
    logic [1:0]             filt_prev_q;
    logic [3:0]             fcnt_q [2];

    assign line_raw[SCL] = scl_sync_q[SYNC_STAGES-1];
    assign line_raw[SDA] = sda_sync_q[SYNC_STAGES-1];

    // Shift both bus lines through their synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchronisers reset to 1 (idle bus level) so leaving reset never looks like an SDA/SCL fall.
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Accept a new line level only after it has differed for FILT_CYC consecutive clks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q      <= '1;
            filt_prev_q <= '1;
            // NOTE: the tiny per-line counter array is reset explicitly; it is control state, not storage.
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (line_raw[i] != filt_q[i]) begin
                    if (fcnt_q[i] == 4'(FILT_CYC - 1)) begin
                        filt_q[i] <= line_raw[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 4'd1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus events from the filtered lines (valid for exactly one clk)
    // ------------------------------------------------------------------
    logic scl_rise;
    logic scl_high;
    logic start_ev;
    logic stop_ev;

    assign scl_rise = filt_q[SCL] & ~filt_prev_q[SCL];
    assign scl_high = filt_q[SCL] &  filt_prev_q[SCL];
    assign start_ev = scl_high & ~filt_q[SDA] &  filt_prev_q[SDA];
    assign stop_ev  = scl_high &  filt_q[SDA] & ~filt_prev_q[SDA];

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       from_addr_q, from_addr_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       ack_q, ack_d;
    logic       is_addr_q, is_addr_d;
    logic       rw_q, rw_d;
    logic       start_q, start_d;
    logic       rstart_q, rstart_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;
    logic       ferr_q, ferr_d;
    logic       partial;

    // A START/STOP arriving now would cut a byte short.
    assign partial = (bit_cnt_q != 4'd0) || (state_q == ST_ACK);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; START/STOP take priority over a coincident SCL rise.
    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        state_d = state_q;
        if (stop_ev) begin
            state_d = ST_IDLE;
        end else if (start_ev) begin
            state_d = ST_ADDR;
        end else if (scl_rise) begin
            unique case (state_q)
                ST_ADDR, ST_DATA: if (bit_cnt_q == 4'd7) state_d = ST_ACK;
                ST_ACK:           state_d = ST_DATA;
                default:          state_d = state_q;
            endcase
        end
    end

    // Output / datapath next values.
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        from_addr_d = from_addr_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        ack_d       = ack_q;
        is_addr_d   = is_addr_q;
        rw_d        = rw_q;
        start_d     = 1'b0;
        rstart_d    = 1'b0;
        stop_d      = 1'b0;
        busy_d      = busy_q;
        ferr_d      = 1'b0;
        if (stop_ev) begin
            stop_d    = 1'b1;
            busy_d    = 1'b0;
            ferr_d    = partial;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (start_ev) begin
            start_d   = (state_q == ST_IDLE);
            rstart_d  = (state_q != ST_IDLE);
            ferr_d    = partial;
            busy_d    = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (scl_rise) begin
            unique case (state_q)
                ST_ADDR, ST_DATA: begin
                    shift_d   = {shift_q[6:0], filt_q[SDA]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) from_addr_d = (state_q == ST_ADDR);
                end
                ST_ACK: begin
                    valid_d   = 1'b1;
                    byte_d    = shift_q;
                    ack_d     = filt_q[SDA];
                    is_addr_d = from_addr_q;
                    if (from_addr_q) rw_d = shift_q[0];
                    bit_cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            from_addr_q <= 1'b0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            ack_q       <= 1'b0;
            is_addr_q   <= 1'b0;
            rw_q        <= 1'b0;
            start_q     <= 1'b0;
            rstart_q    <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            from_addr_q <= from_addr_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            is_addr_q   <= is_addr_d;
            rw_q        <= rw_d;
            start_q     <= start_d;
            rstart_q    <= rstart_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
            ferr_q      <= ferr_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign ack_out    = ack_q;
    assign is_addr    = is_addr_q;
    assign rw         = rw_q;
    assign start_det  = start_q;
    assign rstart_det = rstart_q;
    assign stop_det   = stop_q;
    assign bus_busy   = busy_q;
    assign frame_err  = ferr_q;

endmodule
